// File: rtl/disp_7seg_rx_if.sv
// Bus between a multiplexed 7-segment display scan and the frame receiver.
// The master drives raw digit enables/segments; the slave publishes decoded frames.
interface disp_7seg_rx_if;
    logic [7:0]  e_in;
    logic [7:0]  q_in;
    logic [31:0] out;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [7:0]  err;
    logic        valid;
    logic        stale;

    modport master (
        output e_in, q_in,
        input  out, dp, en, err, valid, stale
    );

    modport slave (
        input  e_in, q_in,
        output out, dp, en, err, valid, stale
    );
endinterface

// File: rtl/disp_7seg_rx.sv
// Captures digits from a scanned, active-low 7-segment display bus and
// publishes one decoded frame each time a digit index repeats.
module disp_7seg_rx #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic                i_clk,
    input  logic                i_clr,
    disp_7seg_rx_if.slave       bus
);
    localparam int unsigned STAB_W = 8;
    localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {ST_WAIT = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_e_s1, r_e_s2, r_e_d;
    logic [7:0]        r_q_s1, r_q_s2, r_q_d;
    logic [STAB_W-1:0] r_stab, w_stab_nxt;
    logic [IDLE_W-1:0] r_idle;
    logic [7:0][3:0]   r_sh_nib;
    logic [7:0]        r_sh_dp, r_sh_err, r_seen;
    logic [31:0]       r_out;
    logic [7:0]        r_dp, r_en, r_err;
    logic              r_valid, r_stale;

    logic              w_change, w_eval, w_single, w_capture, w_bad, w_dp;
    logic [7:0]        w_act;
    logic [2:0]        w_idx;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg;

    // Two-flop synchronizer plus one delayed copy for change detection
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_e_s1 <= 8'hFF;
            r_e_s2 <= 8'hFF;
            r_e_d  <= 8'hFF;
            r_q_s1 <= 8'hFF;
            r_q_s2 <= 8'hFF;
            r_q_d  <= 8'hFF;
        end else begin
            r_e_s1 <= bus.e_in;
            r_e_s2 <= r_e_s1;
            r_e_d  <= r_e_s2;
            r_q_s1 <= bus.q_in;
            r_q_s2 <= r_q_s1;
            r_q_d  <= r_q_s2;
        end
    end

    assign w_change = ({r_e_s2, r_q_s2} != {r_e_d, r_q_d});

    // Stability count includes the current sample, so it reads 1 on a change
    always_comb begin
        w_stab_nxt = r_stab;
        if (w_change)
            w_stab_nxt = STAB_W'(1);
        else if (r_stab >= STAB_W'(SETTLE))
            w_stab_nxt = STAB_W'(SETTLE);
        else
            w_stab_nxt = r_stab + STAB_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) r_stab <= '0;
        else       r_stab <= w_stab_nxt;
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) r_state <= ST_WAIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_stab_nxt == STAB_W'(SETTLE)) begin
                    w_eval      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_change) w_state_nxt = ST_WAIT;
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    // Digit selection and glyph decode of the synchronized pattern
    always_comb begin
        w_act    = ~r_e_s2;
        w_single = (w_act != 8'h00) && ((w_act & (w_act - 8'h01)) == 8'h00);
        w_idx    = 3'd0;
        for (int n = 0; n < 8; n++) begin
            if (w_act[n]) w_idx = 3'(n);
        end
        w_seg = ~r_q_s2[6:0];
        w_dp  = ~r_q_s2[7];
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (w_seg)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_bad = 1'b1;
        endcase
    end

    assign w_capture = w_eval & w_single;

    // Shadow frame, frame close on repeated index, idle timeout publish
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_idle   <= '0;
            r_sh_nib <= '0;
            r_sh_dp  <= '0;
            r_sh_err <= '0;
            r_seen   <= '0;
            r_out    <= '0;
            r_dp     <= '0;
            r_en     <= '0;
            r_err    <= '0;
            r_valid  <= 1'b0;
            r_stale  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_capture) begin
                r_idle  <= '0;
                r_stale <= 1'b0;
                if (r_seen[w_idx]) begin
                    r_out    <= r_sh_nib;
                    r_dp     <= r_sh_dp;
                    r_err    <= r_sh_err;
                    r_en     <= r_seen;
                    r_valid  <= 1'b1;
                    r_sh_nib <= '0;
                    r_sh_dp  <= '0;
                    r_sh_err <= '0;
                    r_seen   <= '0;
                end
                r_sh_nib[w_idx] <= w_nib;
                r_sh_dp[w_idx]  <= w_dp;
                r_sh_err[w_idx] <= w_bad;
                r_seen[w_idx]   <= 1'b1;
            end else if (r_idle != IDLE_W'(TIMEOUT)) begin
                r_idle <= r_idle + IDLE_W'(1);
                if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
                    r_stale  <= 1'b1;
                    r_out    <= '0;
                    r_dp     <= '0;
                    r_en     <= '0;
                    r_err    <= '0;
                    r_valid  <= 1'b1;
                    r_sh_nib <= '0;
                    r_sh_dp  <= '0;
                    r_sh_err <= '0;
                    r_seen   <= '0;
                end
            end
        end
    end

    assign bus.out   = r_out;
    assign bus.dp    = r_dp;
    assign bus.en    = r_en;
    assign bus.err   = r_err;
    assign bus.valid = r_valid;
    assign bus.stale = r_stale;
endmodule

// File: tb/tb_disp_7seg_rx.sv
// Scoreboard bench: a segment-level display model predicts every published frame.
module tb_disp_7seg_rx;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 300;
    localparam int          LONG_IDLE = TIMEOUT + 60;

    typedef struct packed {
        logic [31:0] out;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic [7:0]  err;
    } frame_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    disp_7seg_rx_if bus();

    disp_7seg_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (bus)
    );

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    frame_t     exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         gap   = 0;

    // display model state: what a human reading the scan would have seen
    logic [3:0] m_nib [8];
    logic [7:0] m_dp, m_err, m_seen;
    logic       m_stale;
    logic [15:0] m_last;
    int         m_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic decode(input logic [7:0] q, output logic [3:0] nib, output logic err, output logic dpb);
        logic [6:0] s;
        s   = ~q[6:0];
        dpb = ~q[7];
        nib = 4'h0;
        err = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == s) begin
                nib = 4'(i);
                err = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 8; n++) m_nib[n] = 4'h0;
        m_dp = '0; m_err = '0; m_seen = '0;
    endtask

    task automatic model_reset();
        model_clear();
        m_stale = 1'b0;
        m_last  = 16'hFFFF;
        m_run   = SETTLE;
    endtask

    task automatic model_seg(input logic [7:0] e, input logic [7:0] q, input int d, output bit cap);
        int prev;
        int idx;
        frame_t f;
        logic [3:0] nib;
        logic er, dpb;
        cap  = 1'b0;
        prev = ({e, q} == m_last) ? m_run : 0;
        m_run  = prev + d;
        m_last = {e, q};
        if (prev < int'(SETTLE) && m_run >= int'(SETTLE) && $countones(~e) == 1) begin
            cap = 1'b1;
            idx = 0;
            for (int n = 0; n < 8; n++) if (!e[n]) idx = n;
            if (m_seen[idx]) begin
                for (int n = 0; n < 8; n++) f.out[4*n +: 4] = m_nib[n];
                f.dp = m_dp; f.en = m_seen; f.err = m_err;
                exp_q.push_back(f);
                model_clear();
            end
            decode(q, nib, er, dpb);
            m_nib[idx]  = nib;
            m_dp[idx]   = dpb;
            m_err[idx]  = er;
            m_seen[idx] = 1'b1;
            m_stale     = 1'b0;
        end else if (e == 8'hFF && d >= LONG_IDLE && !m_stale) begin
            exp_q.push_back('0);
            model_clear();
            m_stale = 1'b1;
        end
    endtask

    task automatic seg(input logic [7:0] e, input logic [7:0] q, input int d);
        bit cap;
        bus.e_in = e;
        bus.q_in = q;
        model_seg(e, q, d, cap);
        if (cap) gap = 0;
        else     gap += d;
        repeat (d) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [7:0] q0, q1, q2, q3);
        seg(8'hFE, q0, 20);
        seg(8'hFD, q1, 20);
        seg(8'hFB, q2, 20);
        seg(8'hF7, q3, 20);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"},   bus.out, 32'h0);
        chk({tag, "_dp"},    32'(bus.dp), 32'h0);
        chk({tag, "_en"},    32'(bus.en), 32'h0);
        chk({tag, "_err"},   32'(bus.err), 32'h0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
        chk({tag, "_stale"}, 32'(bus.stale), 32'h0);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        bus.e_in = 8'hFF;
        bus.q_in = 8'hFF;
        model_reset();
        gap = 0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Monitor: every VALID pulse must match the oldest predicted frame
    always @(negedge clk) begin
        frame_t f;
        if (!clr && bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=%0h required=none at %0t", bus.out, $time);
            end else begin
                f = exp_q.pop_front();
                chk("frame_out", bus.out, f.out);
                chk("frame_dp",  32'(bus.dp),  32'(f.dp));
                chk("frame_en",  32'(bus.en),  32'(f.en));
                chk("frame_err", 32'(bus.err), 32'(f.err));
            end
        end
    end

    initial begin
        int r, idx, nseg, len;
        logic [7:0] e, q;

        clr = 1'b1;
        bus.e_in = 8'hFF;
        bus.q_in = 8'hFF;
        model_reset();
        #2;
        chk_zero("init");
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;

        // two clean scans of 4-3-2-1 close one frame at the recapture of digit 0
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        chk("scan_out", bus.out, 32'h00001234);
        chk("scan_en",  32'(bus.en), 32'h0F);
        chk("scan_dp",  32'(bus.dp), 32'h0);
        chk("scan_err", 32'(bus.err), 32'h0);

        scan4(8'h99, 8'h30, 8'hA4, 8'hF9);
        scan4(8'h99, 8'hB0, 8'hFF, 8'hF9);
        chk("dp_out", bus.out, 32'h00001234);
        chk("dp_dp",  32'(bus.dp), 32'h02);

        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        chk("blank_out", bus.out, 32'h00001034);
        chk("blank_err", 32'(bus.err), 32'h04);

        // digit 0 shown too briefly to settle
        seg(8'hFD, 8'hB0, 20);
        seg(8'hFB, 8'hA4, 20);
        seg(8'hF7, 8'hF9, 20);
        seg(8'hFE, 8'h99, SETTLE - 1);
        seg(8'hFD, 8'hB0, 20);
        chk("glitch_en",  32'(bus.en), 32'h0E);
        chk("glitch_out", bus.out, 32'h00001230);

        // scan stops long enough to go stale, then resumes
        seg(8'hFF, 8'hFF, LONG_IDLE);
        chk("stale_set", 32'(bus.stale), 32'h1);
        chk("stale_out", bus.out, 32'h0);
        chk("stale_en",  32'(bus.en), 32'h0);
        seg(8'hFE, 8'h99, 20);
        chk("stale_clr", 32'(bus.stale), 32'h0);
        seg(8'hFD, 8'hB0, 20);
        seg(8'hFE, 8'h99, 20);
        chk("resume_en",  32'(bus.en), 32'h03);
        chk("resume_out", bus.out, 32'h00000034);

        // reset mid-frame discards the partial frame
        seg(8'hFD, 8'hB0, 20);
        seg(8'hFB, 8'hA4, 20);
        do_reset();
        seg(8'hF7, 8'hF9, 20);
        seg(8'hFE, 8'h99, 20);
        seg(8'hF7, 8'hF9, 20);
        chk("post_rst_en",  32'(bus.en), 32'h09);
        chk("post_rst_out", bus.out, 32'h00001004);

        // randomized bursts of scanning, glitches, ghosting and gaps
        for (int b = 0; b < 12; b++) begin
            nseg = int'($urandom_range(10, 25));
            for (int s = 0; s < nseg; s++) begin
                r = int'($urandom_range(0, 9));
                if (gap > 150) r = 0;
                if (r <= 7) begin
                    idx = int'($urandom_range(0, 7));
                    e   = ~(8'h01 << idx);
                    if (e == m_last[15:8]) e = {e[6:0], e[7]};
                    if ($urandom_range(0, 9) == 0) q = 8'($urandom);
                    else q = ~{1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
                    len = (r == 7) ? int'(SETTLE) - 1 : int'($urandom_range(8, 30));
                    seg(e, q, len);
                end else if (r == 8) begin
                    e = 8'($urandom) & ~(8'h03 << $urandom_range(0, 6));
                    seg(e, 8'($urandom), int'($urandom_range(5, 20)));
                end else begin
                    seg(8'hFF, 8'($urandom), int'($urandom_range(5, 20)));
                end
            end
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                seg(8'hFF, 8'hFF, LONG_IDLE);
                chk("rand_stale", 32'(bus.stale), 32'h1);
            end else if (r == 1) begin
                do_reset();
            end
        end

        bus.e_in = 8'hFF;
        bus.q_in = 8'hFF;
        repeat (50) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/disp_7seg_rx.md
DISP_7SEG_RX -- requirements
Module: disp_7seg_rx

Interface
REQ-001 Parameter SETTLE, default 4: number of consecutive identical synchronized samples of (E_IN,Q_IN) required before a digit is captured; legal range 2..255.
REQ-002 Parameter TIMEOUT, default 20'd1000000: number of CLK cycles without any capture before the STALE flag is raised.
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 CLR  input  1  reset, asynchronous, active-high.
REQ-005 E_IN  input  8  digit enables from a multiplexed 7-segment display; active-low; bit n selects digit n.
REQ-006 Q_IN  input  8  segment lines, active-low; Q_IN[0..6] = segments a..g, Q_IN[7] = DP.
REQ-007 OUT  output  32  decoded frame; OUT[4n+3:4n] is the nibble of digit n.
REQ-008 DP  output  8  decimal-point state per digit (1 = lit).
REQ-009 EN  output  8  digit-present mask for the published frame (1 = digit was scanned).
REQ-010 ERR  output  8  per-digit flag: the segment pattern was not a valid hex glyph.
REQ-011 VALID  output  1  one-cycle pulse marking that OUT/DP/EN/ERR were just updated.
REQ-012 STALE  output  1  high while no digit has been captured for TIMEOUT cycles.

Function
REQ-013 E_IN and Q_IN shall pass through a two-flop synchronizer; all further logic uses only the synchronized values.
REQ-014 A stability counter shall count consecutive cycles in which the synchronized (E,Q) equals the previous cycle's value; it reloads to 1 on any change and saturates at SETTLE.
REQ-015 FSM states shall be WAIT (pattern unstable), HOLD (pattern stable and already handled).
REQ-016 WAIT -> HOLD on the first cycle the counter reaches SETTLE; that cycle is the evaluation cycle. HOLD -> WAIT on any change of synchronized (E,Q).
REQ-017 In the evaluation cycle, if exactly one bit of synchronized E is low, a capture of that digit index i occurs; zero or multiple low bits cause no capture and no other state change.
REQ-018 Glyph decode (segments a..g as bit0..6, active-high after inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 An undecodable glyph shall be stored as nibble 0 with its shadow ERR bit set; a decodable glyph clears that bit.
REQ-020 A capture shall write the nibble, DP bit and ERR bit of digit i into a shadow frame and set bit i of a seen-mask.
REQ-021 Frame close: if bit i of the seen-mask is already set at capture time, then on the same edge OUT/DP/ERR shall load the shadow frame as it stood before this capture, EN shall load the seen-mask, VALID shall pulse, the shadow shall be cleared, and the seen-mask shall become only bit i, with digit i's new data written.
REQ-022 Shadow entries for digits not captured in a frame shall be 0, so published OUT/DP/ERR bits of absent digits (EN bit 0) are 0.
REQ-023 Frame closing is independent of scan order or direction; one repeated digit index suffices.
REQ-024 An idle counter shall reset to 0 on every capture and otherwise increment, saturating at TIMEOUT; STALE = (idle counter == TIMEOUT).
REQ-025 When the idle counter first reaches TIMEOUT, the block shall publish an empty frame (OUT, DP, ERR, EN = 0), pulse VALID once, and clear the shadow and seen-mask.
REQ-026 The first capture after STALE shall deassert STALE on the next edge and shall not close a frame.
REQ-027 Capture latency: first evaluation occurs SETTLE+1 cycles after a new value is presented on the raw inputs (2 sync stages plus settle counting).
REQ-028 Outputs shall hold their values between VALID pulses.

Reset
REQ-029 While CLR is high, asynchronously: synchronizers = 8'hFF (idle lines), counters = 0, FSM = WAIT, shadow and seen-mask = 0, OUT = 0, DP = 0, EN = 0, ERR = 0, VALID = 0, STALE = 0.
REQ-030 CLR asserted mid-frame shall discard the partial frame; no VALID shall be generated for it after release.

Verification
REQ-031 Scan E_IN = FE/FD/FB/F7, Q_IN = 99/B0/A4/F9, 1000 cycles per digit, two full scans -> one VALID at the first recapture of digit 0: OUT = 32'h00001234, EN = 8'h0F, DP = 0, ERR = 0.
REQ-032 Same scan with digit 1 using Q_IN = 30 (DP lit) -> DP = 8'h02, OUT = 32'h00001234.
REQ-033 Digit 2 glyph Q_IN = FF (blank) -> ERR = 8'h04, OUT[11:8] = 0, other nibbles intact.
REQ-034 Glitch: digit 0 value held for only SETTLE-1 synchronized cycles between digits -> no capture, EN bit 0 = 0.
REQ-035 Scan stopped (E_IN = FF) for TIMEOUT cycles -> STALE = 1, one VALID with OUT = 0 and EN = 0; resume scanning -> STALE = 0 after first capture, next VALID at first repeated index.
REQ-036 CLR pulse after capturing digits 0..2 -> all outputs 0 immediately; next VALID reports only digits scanned after release.
